// File: rtl/aes_round_sequencer_if.sv
// Host-side bundle for the AES round sequencer: plaintext/key in, ciphertext out.
//
// Handshake semantics (both directions): a transfer happens on a rising clock
// edge where valid and ready are both 1. The producer holds valid and its data
// stable until that edge. Ready may be asserted with or without valid.
interface aes_round_sequencer_if #(
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] plaintext;
    logic [DATA_W-1:0] key;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ciphertext;

    // Host side: offers blocks, consumes ciphertext.
    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext
    );

    // Sequencer side.
    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller. Runs one round per clock through an
// external combinational round datapath and key expander, holding the running
// state and round key locally. All outputs come from registers or are decoded
// from the FSM state, so there is no combinational path from inputs to outputs.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int DATA_W     = 128
) (
    input  logic              clock,
    input  logic              rst_n,
    aes_round_sequencer_if.slave host,
    output logic              busy,
    output logic [DATA_W-1:0] rnd_din,
    output logic [DATA_W-1:0] rnd_kin,
    output logic [3:0]        rnd_count,
    output logic              rnd_last,
    input  logic [DATA_W-1:0] rnd_dout,
    input  logic [DATA_W-1:0] rnd_kout,
    output logic [1:0]        fsm_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] state_reg;
    logic [DATA_W-1:0] key_reg;
    logic [DATA_W-1:0] ct_reg;
    logic [3:0]        round_cnt;
    logic              accept;
    logic              step;
    logic              finish;

    // FSM state register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the load/advance/finish strobes for the datapath registers.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (host.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                step = 1'b1;
                if (round_cnt == LAST_ROUND) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (host.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Running state, round key and round index. The accept cycle folds in the
    // round-0 AddRoundKey; the counter parks at the last round instead of wrapping.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
            key_reg   <= '0;
            round_cnt <= 4'd0;
        end else if (accept) begin
            state_reg <= host.plaintext ^ host.key;
            key_reg   <= host.key;
            round_cnt <= 4'd1;
        end else if (step) begin
            state_reg <= rnd_dout;
            key_reg   <= rnd_kout;
            if (!finish) begin
                round_cnt <= round_cnt + 4'd1;
            end
        end
    end

    // Ciphertext capture on the last round; held through any output stall.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ct_reg <= '0;
        end else if (finish) begin
            ct_reg <= rnd_dout;
        end
    end

    // Outputs decoded from the FSM state; datapath operands are zeroed outside ROUND.
    always_comb begin
        host.in_ready   = (state == IDLE);
        host.out_valid  = (state == DONE);
        host.ciphertext = ct_reg;
        busy            = (state == ROUND);
        rnd_din         = (state == ROUND) ? state_reg : '0;
        rnd_kin         = (state == ROUND) ? key_reg : '0;
        rnd_count       = (state == ROUND) ? round_cnt : 4'd0;
        rnd_last        = (state == ROUND) && (round_cnt == LAST_ROUND);
        fsm_state       = state;
    end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer. Supplies an AES-128 round datapath and key
// expander as combinational functions, drives FIPS-197 and random blocks, and
// checks ciphertext, latency, round indexing, stalls, ignored inputs and reset.
module tb_aes_round_sequencer;
    localparam int NUM_ROUNDS = 10;
    localparam int DATA_W     = 128;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic              clock = 1'b0;
    logic              rst_n = 1'b0;
    logic              busy;
    logic [DATA_W-1:0] rnd_din;
    logic [DATA_W-1:0] rnd_kin;
    logic [3:0]        rnd_count;
    logic              rnd_last;
    logic [DATA_W-1:0] rnd_dout;
    logic [DATA_W-1:0] rnd_kout;
    logic [1:0]        fsm_state;

    aes_round_sequencer_if #(.DATA_W(DATA_W)) dif ();

    aes_round_sequencer #(.NUM_ROUNDS(NUM_ROUNDS), .DATA_W(DATA_W)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .host      (dif),
        .busy      (busy),
        .rnd_din   (rnd_din),
        .rnd_kin   (rnd_kin),
        .rnd_count (rnd_count),
        .rnd_last  (rnd_last),
        .rnd_dout  (rnd_dout),
        .rnd_kout  (rnd_kout),
        .fsm_state (fsm_state)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [DATA_W-1:0] exp_q[$];
    int                acc_q[$];

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- AES reference functions ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] s;
        logic [7:0] rot;
        r = 8'h01; p = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        s = r; rot = r;
        for (int i = 0; i < 4; i++) begin
            rot = {rot[6:0], rot[7]};
            s = s ^ rot;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk, input logic last);
        logic [7:0]   a[16];
        logic [7:0]   b[16];
        logic [7:0]   c[16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++)
                b[row+4*col] = a[row+4*((col+row)%4)];
        for (int col = 0; col < 4; col++) begin
            if (last) begin
                for (int row = 0; row < 4; row++) c[row+4*col] = b[row+4*col];
            end else begin
                c[4*col+0] = gmul(8'h02, b[4*col]) ^ gmul(8'h03, b[4*col+1]) ^ b[4*col+2] ^ b[4*col+3];
                c[4*col+1] = b[4*col] ^ gmul(8'h02, b[4*col+1]) ^ gmul(8'h03, b[4*col+2]) ^ b[4*col+3];
                c[4*col+2] = b[4*col] ^ b[4*col+1] ^ gmul(8'h02, b[4*col+2]) ^ gmul(8'h03, b[4*col+3]);
                c[4*col+3] = gmul(8'h03, b[4*col]) ^ b[4*col+1] ^ b[4*col+2] ^ gmul(8'h02, b[4*col+3]);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = c[i] ^ rk[127-8*i -: 8];
        return r;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] rnd);
        logic [31:0] w[4];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 1; i < int'(rnd); i++) rc = xtime(rc);
        t = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])} ^ {rc, 24'h0};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // Whole-block reference: round-0 key add, then NUM_ROUNDS rounds.
    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s;
        logic [127:0] rk;
        s = pt ^ k; rk = k;
        for (int r = 1; r <= NUM_ROUNDS; r++) begin
            rk = next_key(rk, 4'(r));
            s  = aes_round(s, rk, r == NUM_ROUNDS);
        end
        return s;
    endfunction

    // Round datapath seen by the DUT.
    assign rnd_kout = next_key(rnd_kin, rnd_count);
    assign rnd_dout = aes_round(rnd_din, rnd_kout, rnd_last);

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_block(input logic [127:0] pt, input logic [127:0] k,
                              input logic [127:0] exp_ct, output int t_acc);
        int waited = 0;
        while (dif.in_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        if (dif.in_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL accept_timeout: in_ready=%b expected 1 within 100 cycles", dif.in_ready);
            t_acc = -1;
            return;
        end
        dif.in_valid  = 1'b1;
        dif.plaintext = pt;
        dif.key       = k;
        t_acc = cyc + 1;
        exp_q.push_back(exp_ct);
        acc_q.push_back(t_acc);
        tick();
        dif.in_valid  = 1'b0;
        dif.plaintext = rand128();
        dif.key       = rand128();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic prev_ov;
        int   d;
        logic [127:0] e;
        prev_ov = 1'b0;
        forever begin
            @(negedge clock);
            if (rst_n === 1'b1) begin
                check("ready_valid_exclusive", 128'(dif.in_ready & dif.out_valid), 128'd0);
                if (acc_q.size() > 0) begin
                    d = cyc - acc_q[0];
                    if (d >= 0 && d < NUM_ROUNDS) begin
                        check("busy_in_round", 128'(busy), 128'd1);
                        check("rnd_count", 128'(rnd_count), 128'(d + 1));
                        check("rnd_last", 128'(rnd_last), 128'(d == NUM_ROUNDS - 1));
                    end
                    // Accept edge plus NUM_ROUNDS further edges: out_valid after 11 edges.
                    if (dif.out_valid && !prev_ov) check("latency", 128'(d), 128'(NUM_ROUNDS));
                end else if (dif.out_valid && !prev_ov) begin
                    check("unexpected_out_valid", 128'(dif.out_valid), 128'd0);
                end
                if (dif.out_valid && dif.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("output_without_block", 128'(dif.out_valid), 128'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ciphertext", dif.ciphertext, e);
                        if (acc_q.size() > 0) void'(acc_q.pop_front());
                    end
                end
                prev_ov = dif.out_valid;
            end else begin
                prev_ov = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t;
        int ts[4];
        logic [127:0] pt;
        logic [127:0] k;

        dif.in_valid  = 1'b0;
        dif.plaintext = '0;
        dif.key       = '0;
        dif.out_ready = 1'b1;
        rst_n         = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state.
        check("rst_in_ready", 128'(dif.in_ready), 128'd1);
        check("rst_out_valid", 128'(dif.out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ciphertext", dif.ciphertext, 128'd0);
        check("rst_rnd_count", 128'(rnd_count), 128'd0);
        check("rst_rnd_last", 128'(rnd_last), 128'd0);
        check("rst_rnd_din", rnd_din, 128'd0);
        check("rst_rnd_kin", rnd_kin, 128'd0);

        // FIPS-197 App. B and App. C.1.
        send_block(PT_B, KEY_B, CT_B, t);
        drain();
        send_block(PT_C, KEY_C, CT_C, t);
        drain();

        // Output stall: ciphertext and handshake state hold for 20 cycles.
        dif.out_ready = 1'b0;
        send_block(PT_B, KEY_B, CT_B, t);
        for (int i = 0; i < 40 && dif.out_valid !== 1'b1; i++) tick();
        check("stall_out_valid_seen", 128'(dif.out_valid), 128'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall_ciphertext", dif.ciphertext, CT_B);
            check("stall_in_ready", 128'(dif.in_ready), 128'd0);
            check("stall_out_valid", 128'(dif.out_valid), 128'd1);
        end
        dif.out_ready = 1'b1;
        tick();
        check("release_in_ready", 128'(dif.in_ready), 128'd1);
        check("release_out_valid", 128'(dif.out_valid), 128'd0);

        // New data offered during ROUND must be ignored.
        send_block(PT_C, KEY_C, CT_C, t);
        for (int i = 0; i < 6; i++) begin
            dif.in_valid  = 1'($urandom_range(0, 1));
            dif.plaintext = rand128();
            dif.key       = rand128();
            tick();
            check("round_in_ready", 128'(dif.in_ready), 128'd0);
        end
        dif.in_valid = 1'b0;
        drain();

        // Reset in round 5 discards the block.
        send_block(PT_B, KEY_B, CT_B, t);
        for (int i = 0; i < 4; i++) tick();
        check("pre_reset_rnd_count", 128'(rnd_count), 128'd5);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        acc_q.delete();
        check("mid_rst_out_valid", 128'(dif.out_valid), 128'd0);
        check("mid_rst_in_ready", 128'(dif.in_ready), 128'd1);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_rnd_count", 128'(rnd_count), 128'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("post_rst_ciphertext", dif.ciphertext, 128'd0);
        send_block(PT_B, KEY_B, CT_B, t);
        drain();

        // Random blocks with random idle gaps.
        for (int n = 0; n < 6; n++) begin
            pt = rand128();
            k  = rand128();
            send_block(pt, k, ref_encrypt(pt, k), t);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
        end
        drain();

        // Back-to-back blocks with out_ready held high.
        for (int n = 0; n < 4; n++) begin
            pt = rand128();
            k  = rand128();
            send_block(pt, k, ref_encrypt(pt, k), ts[n]);
        end
        drain();
        for (int n = 1; n < 4; n++) check("b2b_spacing", 128'(ts[n] - ts[n-1]), 128'(NUM_ROUNDS + 2));

        tick(); tick();
        check("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
